binary_add_subs_operator: RTL and testbench
===========================================

Name: binary_add_subs_operator

Overview:
- Registered WIDTH-bit binary adder/subtractor with carry-in/borrow-in, raw carry-out, zero flag and carry/borrow flag.
- Used as the arithmetic core of the datapath ALU experiments.
- Combinational ripple-carry result is captured into output registers on every clock edge.

Parameters:
- WIDTH, 4, operand and result width in bits (must be ≥1).

Ports:
- clk  input  1  system clock; all outputs update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- c0  input  1  carry-in when adding, borrow-in when subtracting.
- sub  input  1  0 = add, 1 = subtract.
- f  output  WIDTH  registered result.
- c4  output  1  registered raw carry-out of the MSB adder stage.
- zf  output  1  registered zero flag.
- cf  output  1  registered carry flag (add) / borrow flag (subtract).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset: while rst_n = 0, force f = 0, c4 = 0, zf = 0 and cf = 0 immediately, independent of clk.
  - zf = 0 during reset is deliberate: reset state means "no result", not "result zero".
- Release of rst_n is synchronous-safe. The first capture happens on the first rising clk edge with rst_n = 1.
- Adder operands:
  - bx = b XOR {WIDTH{sub}}
  - cin = c0 XOR sub
  - {carry, sum} = a + bx + cin, computed at WIDTH+1 bits.
- Add mode (sub = 0): sum = (a + b + c0) mod 2^WIDTH.
- Subtract mode (sub = 1): sum = (a − b − c0) mod 2^WIDTH, in two's complement.
- Flags, combinational next-state values:
  - f_next = sum
  - c4_next = carry
  - cf_next = carry XOR sub. This is the unsigned carry on add and the unsigned borrow on subtract (1 when a < b + c0).
  - zf_next = 1 exactly when sum == 0.
- Latency: exactly one clock.
  - Inputs sampled at rising edge N appear on the outputs after edge N.
  - New inputs may be applied every cycle. There is no handshake and no stall.
- Inputs may change at any time. Only values present at the rising edge matter.
- Wrap-around: results wrap modulo 2^WIDTH with no saturation.
  - Overflow is shown only via c4/cf.
  - Signed overflow is not reported.
- Reset asserted mid-operation: the pending result is discarded, and outputs go to 0 asynchronously.
- No internal state other than the output registers.

Decomposition:
- Shared package: none required. The WIDTH default (4) may live in the project ALU constants package if one exists.
- Sub-module: full_adder (a, b, cin -> s, cout), instantiated WIDTH times via generate to form the ripple chain.
  - Operand inversion, flag logic and registers stay in the top module.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle with non-zero outputs -> f = 0, c4 = 0, zf = 0, cf = 0 immediately, without waiting for a clk edge.
- Add, no carry: a = 2, b = 3, c0 = 0, sub = 0 -> next cycle f = 5, c4 = 0, zf = 0, cf = 0.
- Add with wrap: a = 15, b = 0, c0 = 1, sub = 0 -> f = 0, c4 = 1, zf = 1, cf = 1.
- Subtract, no borrow: a = 5, b = 3, c0 = 0, sub = 1 -> f = 2, c4 = 1, cf = 0, zf = 0. Then a = 4, b = 4 -> f = 0, zf = 1, c4 = 1, cf = 0.
- Subtract with borrow: a = 3, b = 5, c0 = 0, sub = 1 -> f = 14, c4 = 0, cf = 1, zf = 0. Also a = 0, b = 0, c0 = 1, sub = 1 -> f = 15, c4 = 0, cf = 1.
- Back-to-back and randomized:
  - Change a, b, c0 and sub every cycle for ≥1000 cycles.
  - Compare each output against a reference model computed from the inputs sampled one edge earlier.
  - Include a c0 toggle with sub = 1 (a = 5, b = 3, c0 = 1 -> f = 1, c4 = 1, cf = 0).

Source files
------------

// File: rtl/binary_add_subs_operator_pkg.sv
// rtl/binary_add_subs_operator_pkg.sv - shared constants and types for the add/subtract operator
//
// Purpose : default operand width and the operation encoding on the sub input.
// Contents: DEFAULT_WIDTH, op_mode_e.
package binary_add_subs_operator_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Encoding of the sub input: 0 selects add, 1 selects subtract.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_mode_e;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder stage of the ripple-carry chain
//
// Purpose: single-bit sum and carry generation.
// Ports  : a, b, cin (inputs, 1 bit); s, cout (outputs, 1 bit).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/binary_add_subs_operator.sv
// rtl/binary_add_subs_operator.sv - registered WIDTH-bit ripple-carry adder/subtractor with flags
//
// Purpose: computes a + b + c0 (sub = 0) or a - b - c0 (sub = 1) modulo 2^WIDTH and
//          registers the result together with raw carry-out, zero and carry/borrow flags.
// Ports  : clk   - clock, outputs update on rising edge
//          rst_n - asynchronous active-low reset, clears all outputs
//          a, b  - WIDTH-bit unsigned operands
//          c0    - carry-in (add) / borrow-in (subtract)
//          sub   - 0 add, 1 subtract
//          f     - registered WIDTH-bit result
//          c4    - registered raw carry-out of the MSB stage
//          zf    - registered zero flag (0 while in reset)
//          cf    - registered carry (add) / borrow (subtract) flag
module binary_add_subs_operator
  import binary_add_subs_operator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             sub,
  output logic [WIDTH-1:0] f,
  output logic             c4,
  output logic             zf,
  output logic             cf
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] f_d, f_q;
  logic             c4_d, c4_q;
  logic             zf_d, zf_q;
  logic             cf_d, cf_q;

  // Subtraction is a + ~b + ~c0: inverting b forms the one's complement, and
  // inverting the borrow-in supplies the +1 that completes two's complement.
  assign bx       = b ^ {WIDTH{sub}};
  assign carry[0] = c0 ^ sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (a[i]),
      .b    (bx[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    f_d  = sum;
    c4_d = carry[WIDTH];
    // On subtract the raw carry-out is the inverse of the unsigned borrow.
    cf_d = carry[WIDTH] ^ (op_mode_e'(sub) == OP_SUB);
    zf_d = (sum == '0);
  end

  // Reset state means "no result yet", so zf is cleared rather than set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q  <= '0;
      c4_q <= 1'b0;
      zf_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      f_q  <= f_d;
      c4_q <= c4_d;
      zf_q <= zf_d;
      cf_q <= cf_d;
    end
  end

  assign f  = f_q;
  assign c4 = c4_q;
  assign zf = zf_q;
  assign cf = cf_q;

endmodule

// File: tb/tb_binary_add_subs_operator.sv
// tb/tb_binary_add_subs_operator.sv - self-checking bench for binary_add_subs_operator
module tb_binary_add_subs_operator;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       c0;
  logic       sub;
  logic [3:0] f;
  logic       c4;
  logic       zf;
  logic       cf;

  int checks;
  int errors;

  binary_add_subs_operator #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c0    (c0),
    .sub   (sub),
    .f     (f),
    .c4    (c4),
    .zf    (zf),
    .cf    (cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operand set before a rising edge and return just after that edge.
  task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic tc, input logic ts);
    @(negedge clk);
    a = ta; b = tb; c0 = tc; sub = ts;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [6:0] got;
    rst_n = 1'b0; a = 4'd9; b = 4'd3; c0 = 1'b1; sub = 1'b0;
    #1;
    got = {f, c4, zf, cf};
    checks++;
    if (got !== 7'b0) begin
      errors++;
      $display("FAIL reset_initial: got f/c4/zf/cf=%b expected %b", got, 7'b0);
    end
    // Clock edges while held in reset must not capture anything.
    @(posedge clk); #1;
    got = {f, c4, zf, cf};
    checks++;
    if (got !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", got, 7'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    // First capture after release: 9 + 3 + 1 = 13.
    @(posedge clk); #1;
    got = {f, c4, zf, cf};
    checks++;
    if (got !== {4'd13, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_capture: got %b expected %b", got, {4'd13, 3'b000});
    end
    // Mid-cycle async reset with a zero result pending in the registers: zf must drop.
    drive(4'd15, 4'd0, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    got = {f, c4, zf, cf};
    checks++;
    if (got !== 7'b0) begin
      errors++;
      $display("FAIL reset_async_mid_cycle: got %b expected %b", got, 7'b0);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [6:0] got;
    drive(4'd2, 4'd3, 1'b0, 1'b0);
    got = {f, c4, zf, cf};
    checks++;
    if (got !== {4'd5, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_no_carry: got %b expected %b", got, {4'd5, 3'b000});
    end
    drive(4'd15, 4'd0, 1'b1, 1'b0);
    got = {f, c4, zf, cf};
    checks++;
    if (got !== {4'd0, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_wrap: got %b expected %b", got, {4'd0, 3'b111});
    end
    drive(4'd9, 4'd8, 1'b0, 1'b0);
    got = {f, c4, zf, cf};
    checks++;
    if (got !== {4'd1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_carry_nonzero: got %b expected %b", got, {4'd1, 3'b101});
    end
  endtask

  task automatic test_sub;
    logic [6:0] got;
    drive(4'd5, 4'd3, 1'b0, 1'b1);
    got = {f, c4, zf, cf};
    checks++;
    if (got !== {4'd2, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_no_borrow: got %b expected %b", got, {4'd2, 3'b100});
    end
    drive(4'd4, 4'd4, 1'b0, 1'b1);
    got = {f, c4, zf, cf};
    checks++;
    if (got !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_equal_zero: got %b expected %b", got, {4'd0, 3'b110});
    end
    drive(4'd3, 4'd5, 1'b0, 1'b1);
    got = {f, c4, zf, cf};
    checks++;
    if (got !== {4'd14, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_borrow: got %b expected %b", got, {4'd14, 3'b001});
    end
    drive(4'd0, 4'd0, 1'b1, 1'b1);
    got = {f, c4, zf, cf};
    checks++;
    if (got !== {4'd15, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_borrow_in_only: got %b expected %b", got, {4'd15, 3'b001});
    end
    drive(4'd5, 4'd3, 1'b1, 1'b1);
    got = {f, c4, zf, cf};
    checks++;
    if (got !== {4'd1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_c0_toggle: got %b expected %b", got, {4'd1, 3'b100});
    end
  endtask

  // Reference: plain integer arithmetic; borrow is a negative difference.
  task automatic test_back_to_back;
    logic [6:0] got;
    logic [6:0] exp;
    logic [3:0] ra, rb;
    logic       rc, rs;
    int         r;
    int         bad;
    bad = 0;
    for (int i = 0; i < 1200; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      drive(ra, rb, rc, rs);
      if (!rs) begin
        r   = int'(ra) + int'(rb) + int'(rc);
        exp = {4'(r), (r > 15), ((r % 16) == 0), (r > 15)};
      end else begin
        r   = int'(ra) - int'(rb) - int'(rc);
        exp = {4'(r + 32), (r >= 0), (((r + 32) % 16) == 0), (r < 0)};
      end
      got = {f, c4, zf, cf};
      checks++;
      if (got !== exp) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] a=%0d b=%0d c0=%0d sub=%0d: got %b expected %b",
                   i, ra, rb, rc, rs, got, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_add;
    test_sub;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
